// File: rtl/uart_tx_arbiter.sv
// Frame-atomic round-robin arbiter: up to four byte producers share one uartTx.
// A grant is held until the owner's last byte is taken or its stall times out.
module uart_tx_arbiter #(
   parameter int TIMEOUT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3:0]           srcEnable,
   input  logic [3:0]           srcAvail,
   input  logic [3:0]           srcLast,
   input  logic [31:0]          srcData,
   output logic [3:0]           srcNeeded,
   input  logic [TIMEOUT_W-1:0] timeoutCycles,
   input  logic                 txNeeded,
   output logic                 txAvail,
   output logic [7:0]           txData,
   output logic                 busy,
   output logic [1:0]           grantId,
   output logic                 timeoutFlag,
   input  logic                 clearFlag,
   output logic [15:0]          frameCount
);

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT   = 2'd1,
      ARB_RELEASE = 2'd2
   } arbState_t;

   localparam logic [TIMEOUT_W-1:0] STALL_ONE = TIMEOUT_W'(1);
   localparam logic [TIMEOUT_W-1:0] STALL_ZERO = '0;

   arbState_t            stateReg, stateNext;
   logic [1:0]           grantIdReg, grantIdNext;
   logic [TIMEOUT_W-1:0] stallCntReg, stallCntNext;
   logic [TIMEOUT_W-1:0] stallCntInc;
   logic                 timeoutFlagReg, timeoutFlagNext;
   logic [15:0]          frameCountReg, frameCountNext;
   logic                 txNeededDReg;

   logic [7:0]           srcByte [4];
   logic [3:0]           req;
   logic [3:0]           grantMask;

   logic                 pickFound;
   logic [1:0]           pickId;
   logic [1:0]           cand;

   logic                 ownerAvail;
   logic                 accept;
   logic                 lastAccepted;
   logic                 stalling;
   logic                 timeoutHit;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_src
         assign srcByte[gi]   = srcData[8*gi +: 8];
         assign req[gi]       = srcAvail[gi] & srcEnable[gi];
         assign grantMask[gi] = (grantIdReg == 2'(gi));
      end
   endgenerate

   // Search starts just past the previous owner so every requester gets a turn.
   always_comb begin
      pickFound = 1'b0;
      pickId    = grantIdReg;
      cand      = grantIdReg;
      for (int k = 1; k <= 4; k++) begin
         cand = grantIdReg + 2'(k);
         if (!pickFound && req[cand]) begin
            pickFound = 1'b1;
            pickId    = cand;
         end
      end
   end

   assign ownerAvail   = srcAvail[grantIdReg];
   assign accept       = txNeededDReg & ~txNeeded & ownerAvail;
   assign lastAccepted = accept & srcLast[grantIdReg];
   assign stalling     = txNeeded & ~ownerAvail;
   assign stallCntInc  = stallCntReg + STALL_ONE;
   assign timeoutHit   = stalling && (timeoutCycles != STALL_ZERO)
                         && (stallCntInc == timeoutCycles);

   always_comb begin
      stateNext       = stateReg;
      grantIdNext     = grantIdReg;
      stallCntNext    = stallCntReg;
      timeoutFlagNext = timeoutFlagReg;
      frameCountNext  = frameCountReg;
      txAvail         = 1'b0;
      txData          = srcByte[grantIdReg];
      srcNeeded       = 4'b0000;
      busy            = 1'b0;

      if (clearFlag) begin
         timeoutFlagNext = 1'b0;
      end

      case (stateReg)
         ARB_IDLE: begin
            if (pickFound) begin
               grantIdNext  = pickId;
               stallCntNext = STALL_ZERO;
               stateNext    = ARB_GRANT;
            end
         end

         ARB_GRANT: begin
            busy      = 1'b1;
            txAvail   = ownerAvail;
            srcNeeded = grantMask & {4{txNeeded}};
            stallCntNext = stalling ? stallCntInc : STALL_ZERO;
            // A stalled owner cannot also present a byte, so these never coincide.
            if (lastAccepted) begin
               frameCountNext = frameCountReg + 16'd1;
               stateNext      = ARB_RELEASE;
            end else if (timeoutHit) begin
               timeoutFlagNext = 1'b1;
               stateNext       = ARB_RELEASE;
            end
         end

         // One dead cycle so uartTx never sees the old owner's byte as available.
         ARB_RELEASE: begin
            busy      = 1'b1;
            stateNext = ARB_IDLE;
         end

         default: begin
            stateNext = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg       <= ARB_IDLE;
         grantIdReg     <= 2'd3;
         stallCntReg    <= STALL_ZERO;
         timeoutFlagReg <= 1'b0;
         frameCountReg  <= 16'd0;
         txNeededDReg   <= 1'b0;
      end else begin
         stateReg       <= stateNext;
         grantIdReg     <= grantIdNext;
         stallCntReg    <= stallCntNext;
         timeoutFlagReg <= timeoutFlagNext;
         frameCountReg  <= frameCountNext;
         txNeededDReg   <= txNeeded;
      end
   end

   assign grantId     = grantIdReg;
   assign timeoutFlag = timeoutFlagReg;
   assign frameCount  = frameCountReg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural producers and transmitter, frame-level
// round-robin reference, one printed line per accepted byte.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  srcEnable;
   logic [3:0]  srcAvail;
   logic [3:0]  srcLast;
   logic [31:0] srcData;
   logic [3:0]  srcNeeded;
   logic [15:0] timeoutCycles;
   logic        txNeeded;
   logic        txAvail;
   logic [7:0]  txData;
   logic        busy;
   logic [1:0]  grantId;
   logic        timeoutFlag;
   logic        clearFlag;
   logic [15:0] frameCount;

   int checks = 0;
   int errors = 0;

   logic [8:0] srcQ [4][$];
   logic [8:0] refQ [4][$];
   int         logSrc [$];
   logic [7:0] logByte [$];
   int         expSrc [$];
   logic [7:0] expByte [$];

   bit pendingPop;
   int popSrc;
   int lowTimer;
   int txLimit;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.TIMEOUT_W(16)) dut (
      .clk(clk), .reset(reset), .srcEnable(srcEnable), .srcAvail(srcAvail),
      .srcLast(srcLast), .srcData(srcData), .srcNeeded(srcNeeded),
      .timeoutCycles(timeoutCycles), .txNeeded(txNeeded), .txAvail(txAvail),
      .txData(txData), .busy(busy), .grantId(grantId), .timeoutFlag(timeoutFlag),
      .clearFlag(clearFlag), .frameCount(frameCount)
   );

   task automatic driveSrc();
      logic [8:0] h;
      for (int i = 0; i < 4; i++) begin
         if (srcQ[i].size() > 0) begin
            h = srcQ[i][0];
            srcAvail[i] = 1'b1;
            srcData[8*i +: 8] = h[7:0];
            srcLast[i] = h[8];
         end else begin
            srcAvail[i] = 1'b0;
            srcData[8*i +: 8] = 8'h00;
            srcLast[i] = 1'b0;
         end
      end
   endtask

   // One clock: sample at negedge, run the transmitter model, update producers.
   task automatic tick();
      @(negedge clk);
      checks++;
      if ((srcNeeded & ~(4'b0001 << grantId)) !== 4'b0000) begin
         errors++;
         $display("FAIL needed_onehot srcNeeded=%b grantId=%0d", srcNeeded, grantId);
      end
      checks++;
      if (busy !== 1'b1 && (txAvail !== 1'b0 || srcNeeded !== 4'b0000)) begin
         errors++;
         $display("FAIL idle_outputs txAvail=%b srcNeeded=%b need 0/0000", txAvail, srcNeeded);
      end
      if (pendingPop) begin
         if (srcQ[popSrc].size() > 0) void'(srcQ[popSrc].pop_front());
         pendingPop = 1'b0;
      end else if (txNeeded && txAvail === 1'b1) begin
         logSrc.push_back(int'(grantId));
         logByte.push_back(txData);
         $display("tx #%0d src=%0d data=%02h", logSrc.size(), grantId, txData);
         txNeeded   = 1'b0;
         pendingPop = 1'b1;
         popSrc     = int'(grantId);
         lowTimer   = $urandom_range(3, 0);
      end else if (!txNeeded && logSrc.size() < txLimit) begin
         if (lowTimer == 0) txNeeded = 1'b1;
         else lowTimer--;
      end
      driveSrc();
   endtask

   task automatic doReset();
      reset = 1'b1;
      txNeeded = 1'b0; pendingPop = 1'b0; lowTimer = 0; clearFlag = 1'b0;
      txLimit = 1000; timeoutCycles = 16'd0; srcEnable = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         srcQ[i].delete();
         refQ[i].delete();
      end
      logSrc.delete(); logByte.delete(); expSrc.delete(); expByte.delete();
      driveSrc();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic addFrame(input int src, input int len, input bit withLast);
      logic [8:0] e;
      for (int b = 0; b < len; b++) begin
         e[7:0] = 8'($urandom);
         e[8]   = withLast && (b == len - 1);
         srcQ[src].push_back(e);
         refQ[src].push_back(e);
      end
      driveSrc();
   endtask

   task automatic expectFrame(input int src);
      logic [8:0] e;
      while (refQ[src].size() > 0) begin
         e = refQ[src].pop_front();
         expSrc.push_back(src);
         expByte.push_back(e[7:0]);
         if (e[8]) break;
      end
   endtask

   function automatic int rrPick(input int prev, input logic [3:0] mask);
      for (int k = 1; k <= 4; k++)
         if (mask[(prev + k) % 4]) return (prev + k) % 4;
      return 0;
   endfunction

   function automatic logic [3:0] pendingMask();
      logic [3:0] m;
      for (int i = 0; i < 4; i++) m[i] = (refQ[i].size() > 0);
      return m;
   endfunction

   task automatic checkStream(input string name);
      int n;
      checks++;
      if (logSrc.size() !== expSrc.size()) begin
         errors++;
         $display("FAIL %s_len got=%0d need=%0d", name, logSrc.size(), expSrc.size());
      end
      n = (logSrc.size() < expSrc.size()) ? logSrc.size() : expSrc.size();
      for (int k = 0; k < n; k++) begin
         checks++;
         if (logSrc[k] != expSrc[k] || logByte[k] !== expByte[k]) begin
            errors++;
            $display("FAIL %s_byte%0d got src=%0d data=%02h need src=%0d data=%02h",
                     name, k, logSrc[k], logByte[k], expSrc[k], expByte[k]);
         end
      end
   endtask

   task automatic waitLog(input int n, input string name);
      for (int c = 0; c < 300 && logSrc.size() < n; c++) tick();
      checks++;
      if (logSrc.size() < n) begin
         errors++;
         $display("FAIL %s_wait bytes=%0d need=%0d", name, logSrc.size(), n);
      end
   endtask

   task automatic waitFrames(input int n, input string name);
      for (int c = 0; c < 300 && frameCount !== 16'(n); c++) tick();
      checks++;
      if (frameCount !== 16'(n)) begin
         errors++;
         $display("FAIL %s_frames got=%0d need=%0d", name, frameCount, n);
      end
   endtask

   task automatic test_reset();
      doReset();
      checks++;
      if (busy !== 1'b0 || txAvail !== 1'b0 || srcNeeded !== 4'b0000 ||
          grantId !== 2'd3 || timeoutFlag !== 1'b0 || frameCount !== 16'd0) begin
         errors++;
         $display("FAIL reset_values busy=%b txAvail=%b needed=%b grant=%0d flag=%b frames=%0d need 0 0 0000 3 0 0",
                  busy, txAvail, srcNeeded, grantId, timeoutFlag, frameCount);
      end
   endtask

   task automatic test_single_source();
      logic [7:0] fixedBytes [6] = '{8'h00, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78};
      logic [8:0] e;
      doReset();
      srcEnable = 4'b0001;
      for (int b = 0; b < 6; b++) begin
         e = {(b == 5), fixedBytes[b]};
         srcQ[0].push_back(e);
         refQ[0].push_back(e);
      end
      driveSrc();
      waitLog(6, "single");
      tick();
      checks++;
      if (busy !== 1'b1 || frameCount !== 16'd1) begin
         errors++;
         $display("FAIL single_release busy=%b frames=%0d need 1 1", busy, frameCount);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL single_busy_drop busy=%b need 0", busy);
      end
      expectFrame(0);
      checkStream("single");
   endtask

   task automatic test_round_robin();
      int prev;
      int s;
      doReset();
      for (int i = 0; i < 4; i++) begin
         addFrame(i, 2, 1'b1);
         addFrame(i, 2, 1'b1);
      end
      prev = 3;
      for (int f = 0; f < 5; f++) begin
         s = rrPick(prev, pendingMask());
         expectFrame(s);
         prev = s;
      end
      txLimit = 10;
      waitFrames(5, "rr");
      checkStream("rr");
   endtask

   task automatic test_enable_mask();
      int prev;
      int s;
      doReset();
      srcEnable = 4'b1010;
      for (int i = 0; i < 4; i++)
         for (int f = 0; f < 4; f++) addFrame(i, 2, 1'b1);
      prev = 3;
      for (int f = 0; f < 7; f++) begin
         s = rrPick(prev, pendingMask() & ((f < 5) ? 4'b1010 : 4'b1000));
         expectFrame(s);
         prev = s;
      end
      txLimit = 14;
      waitLog(9, "mask");
      srcEnable = 4'b1000;
      waitFrames(7, "mask");
      for (int c = 0; c < 6; c++) tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL mask_disabled_grant busy=%b grant=%0d need busy 0", busy, grantId);
      end
      checkStream("mask");
   endtask

   task automatic test_timeout();
      int cnt;
      bit hit;
      doReset();
      timeoutCycles = 16'd100;
      addFrame(2, 3, 1'b0);
      waitLog(1, "to");
      addFrame(0, 2, 1'b1);
      waitLog(3, "to");
      cnt = 0; hit = 0;
      for (int c = 0; c < 400; c++) begin
         tick();
         if (timeoutFlag === 1'b1) begin hit = 1; break; end
         if (txNeeded && !srcAvail[2]) cnt++;
      end
      checks++;
      if (!hit || cnt != 100) begin
         errors++;
         $display("FAIL timeout_delay got=%0d hit=%0d need=100", cnt, hit);
      end
      checks++;
      if (busy !== 1'b1 || txAvail !== 1'b0 || frameCount !== 16'd0) begin
         errors++;
         $display("FAIL timeout_release busy=%b txAvail=%b frames=%0d need 1 0 0", busy, txAvail, frameCount);
      end
      waitFrames(1, "to");
      expectFrame(2);
      expectFrame(0);
      checkStream("to");
      checks++;
      if (timeoutFlag !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky flag=%b need 1", timeoutFlag);
      end
      clearFlag = 1'b1;
      tick();
      clearFlag = 1'b0;
      checks++;
      if (timeoutFlag !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear flag=%b need 0", timeoutFlag);
      end
   endtask

   task automatic test_simultaneous();
      int cnt;
      bit hit;
      int dropped;
      doReset();
      timeoutCycles = 16'd5;
      addFrame(1, 1, 1'b0);
      waitLog(1, "sim");
      cnt = 0; hit = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (timeoutFlag === 1'b1) begin hit = 1; break; end
         if (txNeeded && !srcAvail[1]) cnt++;
         if (cnt == 5) clearFlag = 1'b1;
      end
      clearFlag = 1'b0;
      checks++;
      if (!hit || cnt != 5) begin
         errors++;
         $display("FAIL sim_flag_wins got_cnt=%0d hit=%0d need cnt=5 flag=1", cnt, hit);
      end
      tick();
      checks++;
      if (timeoutFlag !== 1'b1) begin
         errors++;
         $display("FAIL sim_flag_hold flag=%b need 1", timeoutFlag);
      end

      doReset();
      timeoutCycles = 16'd0;
      addFrame(1, 1, 1'b0);
      waitLog(1, "zero");
      for (int c = 0; c < 20 && !txNeeded; c++) tick();
      dropped = 0;
      for (int c = 0; c < 70000; c++) begin
         @(negedge clk);
         if (busy !== 1'b1) dropped++;
      end
      checks++;
      if (dropped != 0 || timeoutFlag !== 1'b0 || grantId !== 2'd1 || srcNeeded !== 4'b0010) begin
         errors++;
         $display("FAIL zero_timeout dropped=%0d flag=%b grant=%0d needed=%b need 0 0 1 0010",
                  dropped, timeoutFlag, grantId, srcNeeded);
      end
   endtask

   task automatic test_reset_mid_frame();
      doReset();
      addFrame(1, 2, 1'b1);
      waitFrames(1, "rst");
      addFrame(0, 5, 1'b1);
      waitLog(5, "rst");
      reset = 1'b1;
      tick();
      checks++;
      if (srcNeeded !== 4'b0000 || txAvail !== 1'b0 || frameCount !== 16'd0 ||
          grantId !== 2'd3 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_frame needed=%b txAvail=%b frames=%0d grant=%0d busy=%b need 0000 0 0 3 0",
                  srcNeeded, txAvail, frameCount, grantId, busy);
      end
      doReset();
      addFrame(1, 2, 1'b1);
      addFrame(0, 2, 1'b1);
      expectFrame(rrPick(3, pendingMask()));
      expectFrame(1);
      waitFrames(2, "rst_after");
      checkStream("rst_after");
   endtask

   initial begin
      reset = 1'b1;
      srcEnable = 4'b1111; timeoutCycles = 16'd0; txNeeded = 1'b0; clearFlag = 1'b0;
      srcAvail = 4'b0; srcLast = 4'b0; srcData = 32'h0;
      pendingPop = 1'b0; popSrc = 0; lowTimer = 0; txLimit = 1000;
      test_reset();
      test_single_source();
      test_round_robin();
      test_enable_mask();
      test_timeout();
      test_simultaneous();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
